// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding and command decode for the LCD bus scheduler
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and both home encodings (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == (CMD_HOME | 8'h01)));
    endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// rtl/lcd_bus_scheduler_if.sv - requester handshakes and LCD pin bundle
interface lcd_bus_scheduler_if;

    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       busy;
    logic       rw_out;
    logic       rs_out;
    logic       e_out;
    logic [7:0] db_out;

    modport master (
        output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
        input  req0_ready, req1_ready, busy, rw_out, rs_out, e_out, db_out
    );

    modport slave (
        input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
        output req0_ready, req1_ready, busy, rw_out, rs_out, e_out, db_out
    );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// rtl/lcd_rr_arbiter.sv - two-way round-robin grant, pointer advances on accept
module lcd_rr_arbiter (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_idle,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant,
    output logic o_ready0,
    output logic o_ready1
);

    logic r_last;
    logic w_grant;

    always_comb begin
        w_grant = i_valid1;
        if (i_valid0 && i_valid1) begin
            w_grant = ~r_last;
        end
    end

    assign o_grant  = w_grant;
    assign o_ready0 = i_idle & ~w_grant;
    assign o_ready1 = i_idle & w_grant;

    // Starting at requester 1 lets requester 0 win the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_idle && (i_valid0 || i_valid1)) begin
            r_last <= w_grant;
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// rtl/lcd_bus_scheduler.sv - arbitrates two LCD writers and generates E-strobe timing
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int DIV        = 2,
    parameter int WAIT_SHORT = 4,
    parameter int WAIT_LONG  = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    lcd_bus_scheduler_if.slave  bus
);

    localparam int CNT_MAX = (DIV > WAIT_LONG) ? DIV : WAIT_LONG;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] C_DIV   = CW'(DIV);
    localparam logic [CW-1:0] C_SHORT = CW'(WAIT_SHORT);
    localparam logic [CW-1:0] C_LONG  = CW'(WAIT_LONG);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_rs;
    logic            r_e;
    logic [7:0]      r_db;

    logic            w_idle;
    logic            w_grant;
    logic            w_ready0;
    logic            w_ready1;
    logic            w_xfer;
    logic            w_rs;
    logic [7:0]      w_data;
    logic            w_last;

    assign w_idle = (r_state == ST_IDLE);
    assign w_last = (r_cnt == C_ONE);

    lcd_rr_arbiter u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_idle   (w_idle),
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .o_grant  (w_grant),
        .o_ready0 (w_ready0),
        .o_ready1 (w_ready1)
    );

    assign w_xfer = (bus.req0_valid & w_ready0) | (bus.req1_valid & w_ready1);
    assign w_rs   = w_grant ? bus.req1_rs   : bus.req0_rs;
    assign w_data = w_grant ? bus.req1_data : bus.req0_data;

    // Each phase loads its length and leaves on the cycle the counter reads one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_db    <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_rs    <= w_rs;
                        r_db    <= w_data;
                        r_cnt   <= C_DIV;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_last) begin
                        r_cnt   <= C_DIV;
                        r_e     <= 1'b1;
                        r_state <= ST_PULSE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_PULSE: begin
                    if (w_last) begin
                        r_cnt   <= C_DIV;
                        r_e     <= 1'b0;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_HOLD: begin
                    if (w_last) begin
                        r_cnt   <= is_long_cmd(r_rs, r_db) ? C_LONG : C_SHORT;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_WAIT: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_e     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.busy       = ~w_idle;
    assign bus.rw_out     = 1'b0;
    assign bus.rs_out     = r_rs;
    assign bus.e_out      = r_e;
    assign bus.db_out     = r_db;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb/tb_lcd_bus_scheduler.sv - scoreboard bench for the LCD bus scheduler
module tb_lcd_bus_scheduler;

    localparam int DIV = 2;
    localparam int WS  = 4;
    localparam int WL  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [8:0] sb[$];
    logic e_prev = 1'b0;
    int   e_start = 0;

    lcd_bus_scheduler_if bus ();

    lcd_bus_scheduler #(.DIV(DIV), .WAIT_SHORT(WS), .WAIT_LONG(WL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each E rising edge retires one expected byte; each falling edge checks pulse width.
    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev = 1'b0;
        end else begin
            if (bus.e_out && !e_prev) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    logic [8:0] exp_item;
                    exp_item = sb.pop_front();
                    check("sb_rs", {31'd0, bus.rs_out}, {31'd0, exp_item[8]});
                    check("sb_db", {24'd0, bus.db_out}, {24'd0, exp_item[7:0]});
                end
                e_start = cyc;
            end
            if (!bus.e_out && e_prev) check("e_width", cyc - e_start, DIV);
            e_prev = bus.e_out;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk); #1; k++;
        end
        check("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    // Single req0 write: strobe shape, data stability under input changes, next-ready gap.
    task automatic xfer_gap(input logic rs, input logic [7:0] d, input int gap);
        int k = 0;
        int seen = 0;
        bus.req1_valid = 1'b0;
        bus.req0_rs = rs; bus.req0_data = d; bus.req0_valid = 1'b1;
        #1;
        check("x_ready0", {31'd0, bus.req0_ready}, 32'd1);
        sb.push_back({rs, d});
        while (seen == 0 && k < 40) begin
            @(negedge clk); #1; k++;
            if (k == 1)           check("x_db_t1", {24'd0, bus.db_out}, {24'd0, d});
            if (k == 2)           bus.req0_data = ~d;
            if (k == DIV)         check("x_e_setup", {31'd0, bus.e_out}, 32'd0);
            if (k == DIV + 1)     check("x_e_hi0", {31'd0, bus.e_out}, 32'd1);
            if (k == 2 * DIV)     check("x_e_hi1", {31'd0, bus.e_out}, 32'd1);
            if (k == 2 * DIV + 1) check("x_e_lo", {31'd0, bus.e_out}, 32'd0);
            if (k == gap - 1) begin
                check("x_db_hold", {24'd0, bus.db_out}, {24'd0, d});
                check("x_rs_hold", {31'd0, bus.rs_out}, {31'd0, rs});
                check("x_rw", {31'd0, bus.rw_out}, 32'd0);
                check("x_busy", {31'd0, bus.busy}, 32'd1);
            end
            if (bus.req0_ready) seen = k;
        end
        bus.req0_valid = 1'b0;
        check("x_gap", seen, gap);
    endtask

    task automatic run_n(input logic v0, input logic v1, input int n, input int gap);
        int k = 0;
        int seen = 0;
        int last = -1;
        bus.req0_valid = v0; bus.req1_valid = v1;
        #1;
        while (seen < n && k < 300) begin
            if ((v0 && bus.req0_ready) || (v1 && bus.req1_ready)) begin
                if (last >= 0) check("rr_gap", k - last, gap);
                last = k;
                seen++;
            end
            if (seen < n) begin
                @(negedge clk); #1; k++;
            end
        end
        check("rr_count", seen, n);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    logic       tab_rs  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] tab_d   [7] = '{8'h38, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    int         tab_gap [7] = '{11, 17, 11, 17, 17, 11, 11};

    initial begin
        int k;
        bus.req0_valid = 1'b0; bus.req0_rs = 1'b0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_rs = 1'b0; bus.req1_data = 8'h00;
        do_reset();
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_e", {31'd0, bus.e_out}, 32'd0);
        check("rst_rs", {31'd0, bus.rs_out}, 32'd0);
        check("rst_db", {24'd0, bus.db_out}, 32'd0);
        check("rst_rw", {31'd0, bus.rw_out}, 32'd0);

        for (int i = 0; i < 7; i++) xfer_gap(tab_rs[i], tab_d[i], tab_gap[i]);
        wait_idle();

        do_reset();
        bus.req0_rs = 1'b1; bus.req0_data = 8'hA0;
        bus.req1_rs = 1'b1; bus.req1_data = 8'hB1;
        sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'hB1});
        sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'hB1});
        run_n(1'b1, 1'b1, 4, 11);
        bus.req1_rs = 1'b1; bus.req1_data = 8'h41;
        for (int i = 0; i < 3; i++) sb.push_back({1'b1, 8'h41});
        run_n(1'b0, 1'b1, 3, 11);
        wait_idle();

        bus.req0_rs = 1'b1; bus.req0_data = 8'h55; bus.req0_valid = 1'b1;
        sb.push_back({1'b1, 8'h55});
        k = 0;
        while (!bus.e_out && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check("rm_e_seen", {31'd0, bus.e_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rm_e", {31'd0, bus.e_out}, 32'd0);
        check("rm_rs", {31'd0, bus.rs_out}, 32'd0);
        check("rm_db", {24'd0, bus.db_out}, 32'd0);
        check("rm_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        xfer_gap(1'b1, 8'h55, 11);
        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_left", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Shares the single HD44780-style LCD write bus between two requesters (init/command sequencer and text writer) and generates the E-strobe timing for every transfer. Each requester offers one command or data byte through a valid/ready handshake; a round-robin arbiter picks one, and the block drives rs/db, pulses E, and enforces the controller's post-write execution delay before accepting the next byte. It sits between the requesters and the LCD pins, replacing direct pin drive by either requester.

## Interface
- DIV, 2: clock cycles per strobe phase (setup, E high, hold); ≥1.
- WAIT_SHORT, 4: execution-wait cycles after an ordinary command or data write; ≥1.
- WAIT_LONG, 10: execution-wait cycles after clear (0x01) or home (0x02/0x03) commands; ≥WAIT_SHORT.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has a byte to write.
- req0_rs / req1_rs  in  1  0 = command, 1 = data.
- req0_data / req1_data  in  8  byte to write.
- req0_ready / req1_ready  out  1  byte accepted this cycle when valid is also high.
- busy  out  1  high whenever state ≠ IDLE.
- rw_out  out  1  tied 0 (write-only bus).
- rs_out  out  1  register select to LCD.
- e_out  out  1  enable strobe to LCD.
- db_out  out  8  data bus to LCD.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WAIT; single down-counter sized clog2(max(DIV, WAIT_LONG)+1).
- IDLE: arbiter grants one valid requester; readyN = (state==IDLE) && grant==N, combinational. Transfer = validN && readyN.
- Round robin: last-served pointer; if both valid, grant the one not last served; if one valid, grant it regardless. Pointer updates only on transfer.
- On transfer: latch rs/data into rs_out/db_out, load counter DIV, go SETUP.
- SETUP (DIV cycles, e_out=0) → PULSE (DIV cycles, e_out=1) → HOLD (DIV cycles, e_out=0) → WAIT.
- WAIT length: WAIT_LONG if latched rs=0 and data[7:2]==0 and data≠0x00; else WAIT_SHORT. Then IDLE.
- rs_out/db_out hold the latched value from transfer until the next transfer (stable through SETUP–WAIT).
- No readyN outside IDLE; requesters must hold valid and data stable until ready. Dropping valid before ready is legal and causes no transfer.
- Reset values: state IDLE, rw_out 0, rs_out 0, e_out 0, db_out 0x00, busy 0, pointer = requester 1 (so requester 0 wins first contention).
- Reset asserted mid-transfer: outputs return to reset values immediately (e_out falls asynchronously); in-flight byte is dropped, no ready is reissued for it.

## Timing
- Transfer at cycle T: rs_out/db_out valid from T+1; e_out high cycles T+1+DIV … T+2·DIV; low again from T+1+2·DIV.
- Next earliest transfer at T+1+3·DIV+W (W = selected wait); back-to-back requests reach this bound with zero idle cycles.
- busy high from T+1 through T+3·DIV+W inclusive.
- E pulse width exactly DIV cycles; setup and hold each exactly DIV cycles.

## Structure
- Package lcd_pkg: state encoding, CMD_CLEAR=8'h01, CMD_HOME=8'h02, long-command decode function.
- Sub-module lcd_rr_arbiter: 2-way round-robin grant with pointer update on accept; everything else in lcd_bus_scheduler.

## Test plan
(DIV=2, WAIT_SHORT=4, WAIT_LONG=10.)
- req0 writes rs=0, 0x38 accepted cycle 0 -> db_out=0x38 from cycle 1, e_out high cycles 3–4, req0_ready next high cycle 11.
- req0 writes rs=0, 0x01 at cycle 0 -> same strobe, next ready cycle 17; repeat with rs=1, 0x01 -> next ready cycle 11.
- Both valid from reset release -> req0 served first, req1 second, req0 third (alternation); single valid requester served back-to-back.
- rst low while e_out=1 -> e_out, rs_out, db_out, busy to 0 same cycle; after release, pending requester accepted in IDLE with fresh strobe.
- Requester changes data while busy -> rs_out/db_out unchanged until next transfer; rw_out 0 throughout.
